// File: rtl/sv32_phys_mem_responder.sv
// sv32_phys_mem_responder: responder end of the MMU physical memory bus.
// This block serves page-table-walk reads and translated loads, stores and
// fetches from a word-addressed internal store. Every request is held off for
// a programmable number of wait states before the single ready pulse.
//
// Ports:
//   clk            rising-edge clock
//   resetn         asynchronous active-low reset
//   mem_valid      request valid, held by the requester until mem_ready
//   mem_ready      single-cycle completion pulse (registered)
//   mem_wstrb      byte enables, 0 means read
//   mem_addr       34-bit physical byte address, bits [1:0] ignored
//   mem_wdata      write data
//   mem_rdata      read data, nonzero only while mem_ready=1
//   bus_error      pulses with mem_ready when the access was rejected
//   protocol_error sticky, set when mem_valid drops before mem_ready
module sv32_phys_mem_responder #(
    parameter logic [33:0] BASE_ADDR   = 34'h0_8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 2,
    parameter bit          READ_ONLY   = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [33:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        bus_error,
    output logic        protocol_error
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [34:0] WIN_BYTES = 35'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [33:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_berr;
    logic        r_perr;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [33:0]      w_acc_addr;
    logic [3:0]       w_acc_wstrb;
    logic [31:0]      w_acc_wdata;
    logic             w_fire;
    logic [34:0]      w_off;
    logic             w_in_win;
    logic [IDX_W-1:0] w_idx;
    logic             w_is_wr;
    logic             w_reject;
    logic             w_do_wr;

    // With zero wait states the access happens on the capture edge itself,
    // so it must use the live bus fields rather than the latched copy.
    assign w_acc_addr  = (r_state == S_IDLE) ? mem_addr  : r_addr;
    assign w_acc_wstrb = (r_state == S_IDLE) ? mem_wstrb : r_wstrb;
    assign w_acc_wdata = (r_state == S_IDLE) ? mem_wdata : r_wdata;

    // Edge that enters RESP and performs the access
    assign w_fire = mem_valid &&
                    (((r_state == S_IDLE) && ZERO_WAIT) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd1)));

    // Full-width window check with one extra bit so the top of the window
    // cannot wrap.
    assign w_off    = {1'b0, w_acc_addr} - {1'b0, BASE_ADDR};
    assign w_in_win = (w_acc_addr >= BASE_ADDR) && (w_off < WIN_BYTES);
    assign w_idx    = w_off[IDX_W+1:2];
    assign w_is_wr  = |w_acc_wstrb;
    assign w_reject = !w_in_win || (w_is_wr && READ_ONLY);
    assign w_do_wr  = resetn && w_fire && w_in_win && w_is_wr && !READ_ONLY;

    // Storage: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Request FSM with registered response outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 34'd0;
            r_wstrb <= 4'd0;
            r_wdata <= 32'd0;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_berr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
            r_berr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_valid) begin
                        r_addr  <= mem_addr;
                        r_wstrb <= mem_wstrb;
                        r_wdata <= mem_wdata;
                        r_cnt   <= WAIT_INIT;
                        if (ZERO_WAIT) begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_berr  <= w_reject;
                            r_rdata <= (!w_reject && !w_is_wr) ? r_mem[w_idx] : 32'd0;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        // Requester abandoned the request: no access, flag it
                        r_perr  <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_berr  <= w_reject;
                        r_rdata <= (!w_reject && !w_is_wr) ? r_mem[w_idx] : 32'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_ready      = r_ready;
    assign mem_rdata      = r_rdata;
    assign bus_error      = r_berr;
    assign protocol_error = r_perr;

endmodule

// File: tb/tb_sv32_phys_mem_responder.sv
// Scoreboard bench for sv32_phys_mem_responder. Four instances cover
// WAIT_STATES=2, 0, 4, and a read-only copy with WAIT_STATES=1. The driver
// pushes the expected response for each request. A negedge monitor pops and
// compares whenever any instance raises mem_ready.
module tb_sv32_phys_mem_responder;

    localparam int NI = 4;
    localparam int unsigned WS [NI] = '{2, 0, 4, 1};

    typedef struct {
        int          k;
        logic [31:0] rd;
        logic        be;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        vld   [NI];
    logic        rdy   [NI];
    logic [3:0]  wstrb [NI];
    logic [33:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic [31:0] rdata [NI];
    logic        berr  [NI];
    logic        perr  [NI];

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        sv32_phys_mem_responder #(
            .BASE_ADDR   (34'h0_8000_0000),
            .DEPTH_WORDS (4096),
            .WAIT_STATES (WS[k]),
            .READ_ONLY   (k == 3)
        ) u_dut (
            .clk            (clk),
            .resetn         (resetn),
            .mem_valid      (vld[k]),
            .mem_ready      (rdy[k]),
            .mem_wstrb      (wstrb[k]),
            .mem_addr       (addr[k]),
            .mem_wdata      (wdata[k]),
            .mem_rdata      (rdata[k]),
            .bus_error      (berr[k]),
            .protocol_error (perr[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rdy[k] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready_inst", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_inst", 32'(k), 32'(e.k));
                    chk("sb_rdata", rdata[k], e.rd);
                    chk("sb_bus_error", 32'(berr[k]), 32'(e.be));
                end
            end
        end
    end

    // One full request: check latency and the idle cycle after ready.
    // Bus fields are scrambled after capture to show they are latched.
    task automatic req(input int k, input logic [33:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] erd, input logic ebe);
        int n;
        exp_t e;
        e.k = k; e.rd = erd; e.be = ebe;
        sb.push_back(e);
        @(posedge clk); #1;
        vld[k] = 1'b1; addr[k] = a; wstrb[k] = s; wdata[k] = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            addr[k] = ~a; wdata[k] = ~d; wstrb[k] = ~s;
        end while (rdy[k] !== 1'b1 && n < 40);
        vld[k] = 1'b0;
        chk("latency", 32'(n), 32'(WS[k] + 1));
        @(posedge clk); #1;
        chk("ready_after", 32'(rdy[k]), 32'd0);
        chk("rdata_after", rdata[k], 32'd0);
        chk("berr_after", 32'(berr[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            vld[k] = 1'b0; wstrb[k] = 4'h0; addr[k] = 34'h0; wdata[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("reset_ready", 32'(rdy[k]), 32'd0);
            chk("reset_rdata", rdata[k], 32'd0);
            chk("reset_berr", 32'(berr[k]), 32'd0);
            chk("reset_perr", 32'(perr[k]), 32'd0);
        end
        resetn = 1'b1;

        // WAIT_STATES=2: write/read, byte lanes, window edges, alias
        req(0, 34'h0_8000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        req(0, 34'h0_8000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        req(0, 34'h0_8000_0020, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        req(0, 34'h0_8000_0020, 4'h5, 32'hAABB_CCDD, 32'h0, 1'b0);
        req(0, 34'h0_8000_0020, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0);
        req(0, 34'h0_7FFF_FFFC, 4'h0, 32'h0, 32'h0, 1'b1);
        req(0, 34'h0_8000_4000, 4'h0, 32'h0, 32'h0, 1'b1);
        req(0, 34'h0_8000_0000, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        req(0, 34'h1_0000_0000, 4'hF, 32'h0000_0000, 32'h0, 1'b1);
        req(0, 34'h0_8000_0000, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        req(0, 34'h0_8000_3FFC, 4'hF, 32'h5A5A_A5A5, 32'h0, 1'b0);
        req(0, 34'h0_8000_3FFC, 4'h0, 32'h0, 32'h5A5A_A5A5, 1'b0);

        // WAIT_STATES=0: preload, then back-to-back reads with valid held
        req(1, 34'h0_8000_0000, 4'hF, 32'h0101_0101, 32'h0, 1'b0);
        req(1, 34'h0_8000_0004, 4'hF, 32'h0202_0202, 32'h0, 1'b0);
        begin
            exp_t e;
            e.k = 1; e.rd = 32'h0101_0101; e.be = 1'b0; sb.push_back(e);
            e.k = 1; e.rd = 32'h0202_0202; e.be = 1'b0; sb.push_back(e);
        end
        @(posedge clk); #1;
        vld[1] = 1'b1; addr[1] = 34'h0_8000_0000; wstrb[1] = 4'h0;
        @(posedge clk); #1;
        chk("b2b_ready_n1", 32'(rdy[1]), 32'd1);
        addr[1] = 34'h0_8000_0004;
        @(posedge clk); #1;
        chk("b2b_ready_n2", 32'(rdy[1]), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ready_n3", 32'(rdy[1]), 32'd1);
        vld[1] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_ready_n4", 32'(rdy[1]), 32'd0);

        // WAIT_STATES=4: abort two cycles after capture, no write, sticky flag
        req(2, 34'h0_8000_0020, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        @(posedge clk); #1;
        vld[2] = 1'b1; addr[2] = 34'h0_8000_0020; wstrb[2] = 4'hF; wdata[2] = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
        end
        vld[2] = 1'b0;
        @(posedge clk); #1;
        chk("abort_perr", 32'(perr[2]), 32'd1);
        chk("abort_ready", 32'(rdy[2]), 32'd0);
        repeat (6) @(posedge clk);
        req(2, 34'h0_8000_0020, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        chk("perr_sticky", 32'(perr[2]), 32'd1);

        // Async reset between edges while in WAIT
        @(posedge clk); #1;
        vld[2] = 1'b1; addr[2] = 34'h0_8000_0020; wstrb[2] = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        resetn = 1'b0;
        vld[2] = 1'b0;
        #1;
        chk("arst_ready", 32'(rdy[2]), 32'd0);
        chk("arst_berr", 32'(berr[2]), 32'd0);
        chk("arst_perr", 32'(perr[2]), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        req(2, 34'h0_8000_0020, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        chk("post_rst_perr", 32'(perr[2]), 32'd0);

        // Read-only copy: writes rejected, out-of-window read rejected
        req(3, 34'h0_8000_0000, 4'hF, 32'h7777_7777, 32'h0, 1'b1);
        req(3, 34'h0_9000_0000, 4'h0, 32'h0, 32'h0, 1'b1);

        repeat (4) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sv32_phys_mem_responder.md
Name: sv32_phys_mem_responder

Overview:
- Responder end of the MMU's physical memory bus: valid/ready, 34-bit physical address, 4-bit byte strobes.
- Serves both page-table-walk reads and final translated loads, stores and fetches from a word-addressed internal store, with a programmable wait-state count.
- Flags out-of-window, read-only-write and requester protocol violations.
- Sits between the sv32 MMU `mem_*` port and on-chip RAM; it is also the bench memory model for MMU verification.

Parameters:
- BASE_ADDR, 34'h0_8000_0000, physical byte address of word 0.
- DEPTH_WORDS, 4096, number of 32-bit words (power of two, ≥ 2).
- WAIT_STATES, 2, idle cycles between request capture and the ready pulse (0..15).
- READ_ONLY, 0, when 1 all writes are dropped and flagged as a bus error.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  reset; one clock; asynchronous, active-low.
- mem_valid  input  1  request valid; held high by the requester until mem_ready.
- mem_ready  output  1  single-cycle completion pulse, registered.
- mem_wstrb  input  4  byte enables; 0 means read.
- mem_addr  input  34  physical byte address; bits [1:0] ignored.
- mem_wdata  input  32  write data.
- mem_rdata  output  32  read data; valid only while mem_ready=1, otherwise 0.
- bus_error  output  1  pulses with mem_ready when the access was rejected.
- protocol_error  output  1  sticky; set when mem_valid drops before mem_ready.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; mem_ready=0, mem_rdata=0, bus_error=0, protocol_error=0, wait counter=0.
  - Storage contents are not cleared.
- States are IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with mem_valid=1: latch addr, wstrb, wdata; load counter=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
  - mem_valid=0: stay.
- WAIT:
  - Counter decrements each cycle; when the counter reaches 1 with mem_valid still 1, go to RESP.
  - mem_valid=0 in WAIT: abort, set protocol_error, go to IDLE, no write performed.
- RESP transition (the edge entering RESP) performs the access:
  - In window means BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH_WORDS; index = (addr − BASE_ADDR)>>2.
  - Read (wstrb=0), in window: mem_rdata = word[index].
  - Write, in window, READ_ONLY=0: update only the byte lanes whose wstrb bit is set; mem_rdata=0.
  - Out of window, or a write with READ_ONLY=1: no state change, mem_rdata=0, bus_error=1.
  - mem_ready=1 for exactly that one cycle.
- RESP → IDLE unconditionally.
  - mem_rdata, bus_error and mem_ready return to 0.
  - If mem_valid is still high in the following IDLE cycle, it is treated as a new request (back-to-back walk reads).
- Latency: request sampled at edge N → mem_ready high in cycle N+1+WAIT_STATES.
  - Minimum turnaround is 2 cycles per request (IDLE + RESP) when WAIT_STATES=0.
- Request fields are latched once in IDLE; changes on mem_addr, mem_wstrb or mem_wdata during WAIT are ignored.
- Address arithmetic uses the full 34 bits; no wrap-around. Addresses at or above 2^32 are legal if inside the window.
- Reset mid-WAIT or mid-RESP: the access is abandoned and no write is committed unless the RESP edge already occurred.
- The requester must hold mem_valid during the RESP cycle (it sees ready combinationally). mem_valid dropping in that cycle is not an error.

Test Plan:
- Write then read, WAIT_STATES=2: write addr 34'h0_8000_0010, wstrb=F, wdata=DEADBEEF. ready 3 cycles after capture, bus_error=0. Read of the same addr returns DEADBEEF on the ready cycle; mem_rdata=0 on the next cycle.
- Byte lanes: word preset to 11223344, write wstrb=0101, wdata=AABBCCDD. Subsequent read returns 11BB33DD.
- Out of window: read 34'h0_7FFF_FFFC and read 34'h0_8000_4000 (DEPTH_WORDS=4096). Each gives ready plus bus_error, rdata=0. A write to 34'h1_0000_0000 is dropped; a read-back at the in-window alias index is unchanged.
- WAIT_STATES=0, mem_valid held high over two back-to-back reads of 34'h0_8000_0000 / 0004: ready pulses on cycles N+1 and N+3 with the correct data each time.
- Protocol abort: with WAIT_STATES=4, drop mem_valid 2 cycles after capture. protocol_error=1 (sticky), no ready pulse, no write. It clears only on resetn=0.
- Async reset asserted mid-WAIT, between clock edges: mem_ready, bus_error, protocol_error and state go to 0 immediately. After release, a fresh read completes normally.
